instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit.
- Reads 16-bit instruction words from a synchronous instruction memory (1-cycle read latency).
- For the immediate opcode, fetches the second (immediate) word, then presents a complete registered instruction (opCode, register fields, immediate, PC) to decode with a valid flag.
- Supports stall from downstream hazard logic, a global enable, and flush/redirect from branch resolution.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// | instruction_fetch_unit_if                                                |
// | Fetch-stage bundle: memory port, pipeline control and decoded outputs.   |
// | Rev 1.0                                                                  |
// ----------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] branchTarget;
  logic [15:0]       imemData;
  logic              imemRdEn;
  logic [ADDR_W-1:0] imemAddr;
  logic              instrValid;
  logic [4:0]        opCode;
  logic [2:0]        rdst;
  logic [2:0]        rsrc1;
  logic [2:0]        rsrc2;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pcOut;

  modport master (
    input  enable, stall, flush, branchTarget, imemData,
    output imemRdEn, imemAddr, instrValid, opCode, rdst, rsrc1, rsrc2, imm, pcOut
  );

  modport slave (
    output enable, stall, flush, branchTarget, imemData,
    input  imemRdEn, imemAddr, instrValid, opCode, rdst, rsrc1, rsrc2, imm, pcOut
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// | instruction_fetch_unit                                                   |
// | Fetches 16-bit words, merges immediate words, presents decoded fields.   |
// | Rev 1.0                                                                  |
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit #(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      IMM_OPCODE = 5'b00001
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_unit_if.master   fif
);

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_CAP_OP  = 2'd1,
    ST_CAP_IMM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [15:2]       pending_q, pending_d;
  logic              valid_q, valid_d;
  logic [4:0]        op_q, op_d;
  logic [2:0]        rdst_q, rdst_d;
  logic [2:0]        rsrc1_q, rsrc1_d;
  logic [2:0]        rsrc2_q, rsrc2_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_START;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      pending_q    <= '0;
      valid_q      <= 1'b0;
      op_q         <= '0;
      rdst_q       <= '0;
      rsrc1_q      <= '0;
      rsrc2_q      <= '0;
      imm_q        <= '0;
      pc_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      pending_q    <= pending_d;
      valid_q      <= valid_d;
      op_q         <= op_d;
      rdst_q       <= rdst_d;
      rsrc1_q      <= rsrc1_d;
      rsrc2_q      <= rsrc2_d;
      imm_q        <= imm_d;
      pc_out_q     <= pc_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    pending_d    = pending_q;
    valid_d      = valid_q;
    op_d         = op_q;
    rdst_d       = rdst_q;
    rsrc1_d      = rsrc1_q;
    rsrc2_d      = rsrc2_q;
    imm_d        = imm_q;
    pc_out_d     = pc_out_q;
    rd_req       = 1'b0;
    rd_addr      = pc_q;
    advance      = 1'b0;

    if (fif.flush) begin
      rd_req       = 1'b1;
      rd_addr      = fif.branchTarget;
      fetch_addr_d = fif.branchTarget;
      pc_d         = fif.branchTarget + ADDR_W'(1);
      pending_d    = '0;
      valid_d      = 1'b0;
      state_d      = ST_CAP_OP;
    end else if (state_q == ST_START) begin
      advance = 1'b1;
      state_d = ST_CAP_OP;
    end else if (fif.stall || !fif.enable) begin
      // Re-read the word under capture so it is still on imemData next cycle.
      rd_req  = 1'b1;
      rd_addr = fetch_addr_q;
      if (!fif.stall) begin
        valid_d = 1'b0;
      end
    end else begin
      advance = 1'b1;
      case (state_q)
        ST_CAP_OP: begin
          if (fif.imemData[15:11] == IMM_OPCODE) begin
            pending_d = fif.imemData[15:2];
            valid_d   = 1'b0;
            state_d   = ST_CAP_IMM;
          end else begin
            op_d     = fif.imemData[15:11];
            rdst_d   = fif.imemData[10:8];
            rsrc1_d  = fif.imemData[7:5];
            rsrc2_d  = fif.imemData[4:2];
            imm_d    = '0;
            pc_out_d = fetch_addr_q;
            valid_d  = 1'b1;
          end
        end
        ST_CAP_IMM: begin
          op_d     = pending_q[15:11];
          rdst_d   = pending_q[10:8];
          rsrc1_d  = pending_q[7:5];
          rsrc2_d  = pending_q[4:2];
          imm_d    = fif.imemData;
          // fetch_addr_q points at the immediate word; the instruction sits one below.
          pc_out_d = fetch_addr_q - ADDR_W'(1);
          valid_d  = 1'b1;
          state_d  = ST_CAP_OP;
        end
        default: begin
          state_d = ST_START;
        end
      endcase
    end

    if (advance) begin
      rd_req       = 1'b1;
      rd_addr      = pc_q;
      fetch_addr_d = pc_q;
      pc_d         = pc_q + ADDR_W'(1);
    end
  end

  assign fif.imemRdEn   = rd_req & ~rst;
  assign fif.imemAddr   = rd_addr;
  assign fif.instrValid = valid_q;
  assign fif.opCode     = op_q;
  assign fif.rdst       = rdst_q;
  assign fif.rsrc1      = rsrc1_q;
  assign fif.rsrc2      = rsrc2_q;
  assign fif.imm        = imm_q;
  assign fif.pcOut      = pc_out_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// | tb_instruction_fetch_unit                                                |
// | Directed bench with an expected-instruction queue for the fetch unit.    |
// | Rev 1.0                                                                  |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_W(16)) ifa ();
  instruction_fetch_unit_if #(.ADDR_W(16)) ifb ();

  instruction_fetch_unit #(
    .ADDR_W(16), .RESET_PC(16'h0000), .IMM_OPCODE(5'b00001)
  ) dut_a (
    .clk(clk), .rst(rst), .fif(ifa.master)
  );

  instruction_fetch_unit #(
    .ADDR_W(16), .RESET_PC(16'hFFFF), .IMM_OPCODE(5'b00001)
  ) dut_b (
    .clk(clk), .rst(rst), .fif(ifb.master)
  );

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];

  always @(posedge clk) if (ifa.imemRdEn) ifa.imemData <= mem_a[ifa.imemAddr];
  always @(posedge clk) if (ifb.imemRdEn) ifb.imemData <= mem_b[ifb.imemAddr];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  rdst;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q [$];
  bit   mon_on = 1'b0;
  bit   adv_a  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] imm, input logic [15:0] pc);
    exp_t e;
    e.op   = w[15:11];
    e.rdst = w[10:8];
    e.rs1  = w[7:5];
    e.rs2  = w[4:2];
    e.imm  = imm;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  // A fresh instruction appears only after an edge where the unit was free to advance.
  always @(posedge clk) adv_a = !rst && ifa.enable && !ifa.stall && !ifa.flush;

  always @(negedge clk) begin
    if (mon_on && adv_a && ifa.instrValid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_extra observed=instr pc=0x%0h op=0x%0h expected=none", ifa.pcOut, ifa.opCode);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_op",    32'(ifa.opCode), 32'(e.op));
        chk("sb_rdst",  32'(ifa.rdst),   32'(e.rdst));
        chk("sb_rsrc1", 32'(ifa.rsrc1),  32'(e.rs1));
        chk("sb_rsrc2", 32'(ifa.rsrc2),  32'(e.rs2));
        chk("sb_imm",   32'(ifa.imm),    32'(e.imm));
        chk("sb_pc",    32'(ifa.pcOut),  32'(e.pc));
      end
    end
  end

  task automatic begin_scn();
    rst              = 1'b1;
    ifa.enable       = 1'b1;
    ifa.stall        = 1'b0;
    ifa.flush        = 1'b0;
    ifa.branchTarget = 16'h0000;
    @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
  endtask

  task automatic end_scn(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    mon_on = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    ifb.enable       = 1'b1;
    ifb.stall        = 1'b0;
    ifb.flush        = 1'b0;
    ifb.branchTarget = 16'h0000;
    begin_scn();
    #1;
    chk("rst_valid", 32'(ifa.instrValid), 32'd0);
    chk("rst_rden",  32'(ifa.imemRdEn),   32'd0);
    chk("rst_op",    32'(ifa.opCode),     32'd0);
    chk("rst_imm",   32'(ifa.imm),        32'd0);
    chk("rst_pc",    32'(ifa.pcOut),      32'd0);

    // Reset release and back-to-back plain instructions; DUT B wraps around.
    mem_a[0] = 16'h2100; mem_a[1] = 16'h4A40;
    mem_b[16'hFFFF] = 16'h0800; mem_b[0] = 16'h1234; mem_b[1] = 16'h2100;
    push(16'h2100, 16'h0000, 16'h0000);
    push(16'h4A40, 16'h0000, 16'h0001);
    mon_on = 1'b1;
    @(negedge clk);
    release_rst();
    chk("s1_start_rden", 32'(ifa.imemRdEn), 32'd1);
    chk("s1_start_addr", 32'(ifa.imemAddr), 32'h0000);
    chk("wrap_start_addr", 32'(ifb.imemAddr), 32'hFFFF);
    @(negedge clk);
    chk("s1_e1_valid", 32'(ifa.instrValid), 32'd0);
    chk("s1_e1_addr",  32'(ifa.imemAddr),   32'h0001);
    @(negedge clk);
    chk("s1_first_valid", 32'(ifa.instrValid), 32'd1);
    chk("s1_first_op",    32'(ifa.opCode),     32'b00100);
    chk("s1_first_rdst",  32'(ifa.rdst),       32'd1);
    chk("s1_first_pc",    32'(ifa.pcOut),      32'h0000);
    chk("wrap_gap_valid", 32'(ifb.instrValid), 32'd0);
    chk("wrap_next_addr", 32'(ifb.imemAddr),   32'h0001);
    @(negedge clk);
    chk("s1_second_rsrc1", 32'(ifa.rsrc1), 32'd2);
    chk("s1_second_pc",    32'(ifa.pcOut), 32'h0001);
    chk("wrap_valid", 32'(ifb.instrValid), 32'd1);
    chk("wrap_op",    32'(ifb.opCode),     32'b00001);
    chk("wrap_imm",   32'(ifb.imm),        32'h1234);
    chk("wrap_pc",    32'(ifb.pcOut),      32'hFFFF);
    ifa.enable = 1'b0;
    #1;
    chk("s1_disable_addr", 32'(ifa.imemAddr), 32'h0002);
    @(negedge clk);
    chk("s1_bubble_valid", 32'(ifa.instrValid), 32'd0);
    chk("s1_bubble_pc",    32'(ifa.pcOut),      32'h0001);
    end_scn("s1_drained");

    // Immediate instruction followed by a plain one.
    begin_scn();
    mem_a[0] = 16'h0B00; mem_a[1] = 16'hBEEF; mem_a[2] = 16'h1000;
    push(16'h0B00, 16'hBEEF, 16'h0000);
    push(16'h1000, 16'h0000, 16'h0002);
    mon_on = 1'b1;
    release_rst();
    @(negedge clk);
    @(negedge clk);
    chk("s2_gap_valid", 32'(ifa.instrValid), 32'd0);
    chk("s2_gap_addr",  32'(ifa.imemAddr),   32'h0002);
    @(negedge clk);
    chk("s2_imm_val",  32'(ifa.imm),  32'hBEEF);
    chk("s2_imm_rdst", 32'(ifa.rdst), 32'd3);
    @(negedge clk);
    chk("s2_plain_imm", 32'(ifa.imm),   32'h0000);
    chk("s2_plain_pc",  32'(ifa.pcOut), 32'h0002);
    ifa.enable = 1'b0;
    @(negedge clk);
    end_scn("s2_drained");

    // Three-cycle stall mid-stream.
    begin_scn();
    mem_a[0] = 16'h3104; mem_a[1] = 16'h5228; mem_a[2] = 16'h734C; mem_a[3] = 16'h9470;
    push(16'h3104, 16'h0000, 16'h0000);
    push(16'h5228, 16'h0000, 16'h0001);
    push(16'h734C, 16'h0000, 16'h0002);
    push(16'h9470, 16'h0000, 16'h0003);
    mon_on = 1'b1;
    release_rst();
    repeat (3) @(negedge clk);
    ifa.stall = 1'b1;
    #1;
    chk("s3_stall_addr0", 32'(ifa.imemAddr), 32'h0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_stall_addr",  32'(ifa.imemAddr),   32'h0002);
      chk("s3_stall_rden",  32'(ifa.imemRdEn),   32'd1);
      chk("s3_stall_valid", 32'(ifa.instrValid), 32'd1);
      chk("s3_stall_pc",    32'(ifa.pcOut),      32'h0001);
      chk("s3_stall_op",    32'(ifa.opCode),     32'b01010);
    end
    ifa.stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("s3_resume_pc", 32'(ifa.pcOut), 32'h0003);
    ifa.enable = 1'b0;
    @(negedge clk);
    end_scn("s3_drained");

    // Flush while waiting for an immediate, with stall asserted at the same time.
    begin_scn();
    mem_a[0] = 16'h0B00; mem_a[1] = 16'hBEEF;
    mem_a[16'h0040] = 16'h2100; mem_a[16'h0041] = 16'h4A40;
    push(16'h2100, 16'h0000, 16'h0040);
    push(16'h4A40, 16'h0000, 16'h0041);
    mon_on = 1'b1;
    release_rst();
    @(negedge clk);
    @(negedge clk);
    ifa.flush = 1'b1;
    ifa.stall = 1'b1;
    ifa.branchTarget = 16'h0040;
    #1;
    chk("s4_flush_addr", 32'(ifa.imemAddr), 32'h0040);
    chk("s4_flush_rden", 32'(ifa.imemRdEn), 32'd1);
    @(negedge clk);
    ifa.flush = 1'b0;
    ifa.stall = 1'b0;
    chk("s4_post_valid", 32'(ifa.instrValid), 32'd0);
    @(negedge clk);
    chk("s4_target_pc",  32'(ifa.pcOut), 32'h0040);
    chk("s4_target_imm", 32'(ifa.imm),   32'h0000);
    @(negedge clk);
    ifa.enable = 1'b0;
    @(negedge clk);
    end_scn("s4_drained");

    // Asynchronous reset while an immediate is pending.
    begin_scn();
    mem_a[0] = 16'h2100; mem_a[1] = 16'h0B00; mem_a[2] = 16'hBEEF;
    push(16'h2100, 16'h0000, 16'h0000);
    mon_on = 1'b1;
    release_rst();
    repeat (3) @(negedge clk);
    chk("s6_pre_op", 32'(ifa.opCode), 32'b00100);
    #3;
    rst = 1'b1;
    #1;
    chk("s6_async_op",    32'(ifa.opCode),     32'd0);
    chk("s6_async_rdst",  32'(ifa.rdst),       32'd0);
    chk("s6_async_valid", 32'(ifa.instrValid), 32'd0);
    chk("s6_async_rden",  32'(ifa.imemRdEn),   32'd0);
    end_scn("s6_first_drained");
    push(16'h2100, 16'h0000, 16'h0000);
    push(16'h0B00, 16'hBEEF, 16'h0001);
    mon_on = 1'b1;
    @(negedge clk);
    release_rst();
    chk("s6_restart_addr", 32'(ifa.imemAddr), 32'h0000);
    repeat (4) @(negedge clk);
    chk("s6_imm_pc", 32'(ifa.pcOut), 32'h0001);
    ifa.enable = 1'b0;
    @(negedge clk);
    end_scn("s6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
